// File: rtl/port_decode_pkg.sv
// Shared sizing and indexing helpers for the registered port decoder.
// Slot numbering is bank-major: slot = bank * NPORT + port.
package port_decode_pkg;

    function automatic int nbank(input int bank_bits);
        return 1 << bank_bits;
    endfunction

    function automatic int nport(input int port_bits);
        return 1 << port_bits;
    endfunction

    function automatic int idx(input int bank, input int port, input int n_port);
        return bank * n_port + port;
    endfunction

    // All-ones value for a saturating counter of width w.
    function automatic longint unsigned sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/strobe_edge.sv
// Rising-edge detector for a processor strobe.
// Produces one go pulse per assertion, however long the strobe is held.
module strobe_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic go
);

    logic strobe_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
        end
    end

    assign go = strobe & ~strobe_q;

endmodule

// File: rtl/port_decode_reg.sv
// Registered port address decoder: one-hot read/write pulses, read-data return mux,
// strict-address checking and sticky collision/address error status.
module port_decode_reg
    import port_decode_pkg::*;
#(
    parameter  int ADDR_W    = 16,
    parameter  int BANK_BITS = 2,
    parameter  int PORT_BITS = 4,
    parameter  int DATA_W    = 16,
    parameter  int STRICT    = 1,
    parameter  int ECNT_W    = 8,
    localparam int NBANK     = nbank(BANK_BITS),
    localparam int NPORT     = nport(PORT_BITS),
    localparam int NSLOT     = NBANK * NPORT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       PORT_ID,
    input  logic                    READ_STROBE,
    input  logic                    WRITE_STROBE,
    input  logic [NSLOT*DATA_W-1:0] RD_DATA,
    input  logic                    ERR_CLR,
    output logic [NSLOT-1:0]        READS,
    output logic [NSLOT-1:0]        WRITES,
    output logic [DATA_W-1:0]       IN_PORT,
    output logic                    RD_VALID,
    output logic                    ADRS_ERR,
    output logic                    COLLIDE,
    output logic [ECNT_W-1:0]       ERR_CNT
);

    localparam int KW = BANK_BITS + PORT_BITS;
    localparam logic [ECNT_W-1:0] ERR_MAX = ECNT_W'(sat_max(ECNT_W));

    logic                 rd_go;
    logic                 wr_go;
    logic [BANK_BITS-1:0] bank;
    logic [PORT_BITS-1:0] port;
    logic [KW-1:0]        k;
    logic [KW-1:0]        kidx;
    logic                 mid_bad;
    logic                 rd_ok;
    logic                 wr_ok;
    logic                 addr_ev;
    logic                 coll_ev;
    logic                 err_ev;
    logic                 rd_pend;
    logic                 rd_bad;
    logic [NSLOT-1:0]     reads_nxt;
    logic [NSLOT-1:0]     writes_nxt;

    strobe_edge u_rd_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (READ_STROBE),
        .go      (rd_go)
    );

    strobe_edge u_wr_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (WRITE_STROBE),
        .go      (wr_go)
    );

    always_comb begin
        bank    = PORT_ID[ADDR_W-1 -: BANK_BITS];
        port    = PORT_ID[PORT_BITS-1:0];
        k       = KW'(idx(int'(bank), int'(port), NPORT));
        mid_bad = 1'b0;
        for (int i = PORT_BITS; i < ADDR_W - BANK_BITS; i++) begin
            mid_bad = mid_bad | PORT_ID[i];
        end
        if (STRICT == 0) begin
            mid_bad = 1'b0;
        end
    end

    // On a collision the read wins; a strict violation suppresses both pulses.
    always_comb begin
        rd_ok      = rd_go & ~mid_bad;
        wr_ok      = wr_go & ~rd_go & ~mid_bad;
        addr_ev    = (rd_go | wr_go) & mid_bad;
        coll_ev    = rd_go & wr_go;
        err_ev     = addr_ev | coll_ev;
        reads_nxt  = '0;
        writes_nxt = '0;
        if (rd_ok) begin
            reads_nxt[k] = 1'b1;
        end
        if (wr_ok) begin
            writes_nxt[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            READS    <= '0;
            WRITES   <= '0;
            kidx     <= '0;
            rd_pend  <= 1'b0;
            rd_bad   <= 1'b0;
            IN_PORT  <= '0;
            RD_VALID <= 1'b0;
        end else begin
            READS    <= reads_nxt;
            WRITES   <= writes_nxt;
            rd_pend  <= rd_go;
            rd_bad   <= addr_ev & rd_go;
            RD_VALID <= rd_pend;
            if (rd_go) begin
                kidx <= k;
            end
            // Rejected reads still return, with zero data, so the core never waits.
            if (rd_pend) begin
                IN_PORT <= rd_bad ? '0 : RD_DATA[int'(kidx)*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ADRS_ERR <= 1'b0;
            COLLIDE  <= 1'b0;
            ERR_CNT  <= '0;
        end else begin
            if (addr_ev) begin
                ADRS_ERR <= 1'b1;
            end else if (ERR_CLR) begin
                ADRS_ERR <= 1'b0;
            end
            if (coll_ev) begin
                COLLIDE <= 1'b1;
            end else if (ERR_CLR) begin
                COLLIDE <= 1'b0;
            end
            if (err_ev) begin
                if (ERR_CLR) begin
                    ERR_CNT <= ECNT_W'(1);
                end else if (ERR_CNT != ERR_MAX) begin
                    ERR_CNT <= ERR_CNT + ECNT_W'(1);
                end
            end else if (ERR_CLR) begin
                ERR_CNT <= '0;
            end
        end
    end

endmodule
